led_frame_sequencer: RTL

Frame scheduler between the I2C register front-end and the LED bit serializer. It shares one single-port colour RAM between I2C byte writes and its own frame reader. On each commit, or on an auto-refresh tick, it streams all `3*LED_CNT` colour bytes in address order to the serializer over a valid/ready handshake, then enforces the latch/reset gap before the next frame.

---
 rtl/ledctrl_pkg.sv | 21 ++
 rtl/ledseq_timer.sv | 26 ++
 rtl/led_frame_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/ledctrl_pkg.sv
// ledctrl_pkg: shared state encoding, constants and sizing helper for the LED frame sequencer
package ledctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DRAIN,
        S_GAP
    } state_t;

    localparam int BYTES_PER_LED    = 3;
    localparam int DEF_RESET_CYCLES = 1500;

    // Bits needed to index n items, never less than one
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ledseq_timer.sv
// ledseq_timer: loadable down-counter that holds at zero and flags done while at zero
module ledseq_timer #(
    parameter int           W    = 11,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload wins over counting; the count saturates at zero
    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    // Count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= INIT;
        else        cnt_q <= cnt_d;

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: streams the colour RAM to the LED serializer per frame; optional auto-refresh under LEDSEQ_AUTOREFRESH_EN
module led_frame_sequencer
    import ledctrl_pkg::*;
#(
    parameter int LED_CNT      = 3,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
`ifdef LEDSEQ_AUTOREFRESH_EN
    parameter int REFRESH_CYCLES = 500000,
`endif
    localparam int BYTES  = BYTES_PER_LED * LED_CNT,
    localparam int ADDR_W = addr_w(BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ready_o,
    input  logic              commit_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              ser_valid_o,
    output logic [7:0]        ser_data_o,
    input  logic              ser_ready_i,
    input  logic              ser_idle_i,
    output logic              busy_o
);

    localparam int                GAP_W   = addr_w(RESET_CYCLES);
    localparam logic [ADDR_W:0]   BYTES_X = (ADDR_W + 1)'(BYTES);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              pending_q, pending_d;
    logic [7:0]        hold_q, hold_d;
    logic              gap_done;
    logic              start;

    // Latch gap: preloaded while draining so it runs exactly RESET_CYCLES GAP cycles
    ledseq_timer #(.W(GAP_W)) u_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == S_DRAIN),
        .load_val_i (GAP_W'(RESET_CYCLES - 1)),
        .en_i       (state_q == S_GAP),
        .done_o     (gap_done)
    );

`ifdef LEDSEQ_AUTOREFRESH_EN
    localparam int REF_W = addr_w(REFRESH_CYCLES);
    logic ref_done;

    // Refresh period: counts only while idle, rearmed whenever a frame runs
    ledseq_timer #(.W(REF_W), .INIT(REF_W'(REFRESH_CYCLES - 1))) u_refresh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q != S_IDLE),
        .load_val_i (REF_W'(REFRESH_CYCLES - 1)),
        .en_i       (state_q == S_IDLE),
        .done_o     (ref_done)
    );

    assign start = commit_i | ref_done;
`else
    assign start = commit_i;
`endif

    // Next-state logic; commits outside IDLE fold into a single pending frame
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        pending_d = pending_q | (commit_i & (state_q != S_IDLE));
        case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                hold_d  = mem_rdata_i;
                state_d = S_SEND;
            end
            S_SEND: if (ser_ready_i) begin
                state_d = (idx_q == LAST) ? S_DRAIN : S_FETCH;
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
            S_DRAIN: state_d = ser_idle_i ? S_GAP : S_DRAIN;
            S_GAP: if (gap_done) begin
                state_d   = pending_d ? S_FETCH : S_IDLE;
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, asynchronously cleared so reset abandons any frame
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end

    assign wr_ready_o  = (state_q != S_FETCH);
    assign mem_we_o    = wr_valid_i & wr_ready_o & ({1'b0, wr_addr_i} < BYTES_X);
    assign mem_addr_o  = (state_q == S_FETCH) ? idx_q : wr_addr_i;
    assign mem_wdata_o = wr_data_i;
    assign ser_valid_o = (state_q == S_SEND);
    assign ser_data_o  = hold_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
